// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter: FSM encoding and sizing.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/dec_2x4_en.sv
// Purpose: 2-to-4 one-hot decoder with enable; output is all-zero when disabled.
// Latency: purely combinational, zero cycles.
// Backpressure: none, a pure function of its inputs.
module dec_2x4_en (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] y
);

    assign y = en ? (4'b0001 << sel) : 4'b0000;

endmodule

// File: rtl/rr_arbiter_4.sv
// Purpose: round-robin arbiter for four requesters with bounded tenure and a turnaround gap.
// Latency: grant one clock after a request is seen in IDLE; next owner two clocks after a release at the earliest.
// Backpressure: level requests, no latching; owner released by done, dropped req or the hold limit.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic             found;

    logic own_done;
    logic own_drop;
    logic at_limit;
    logic release_now;

    // First requesting index in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    always_comb begin
        win_idx = ptr;
        cand    = ptr;
        found   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
    end

    assign own_done    = done[gnt_idx];
    assign own_drop    = !req[gnt_idx];
    assign at_limit    = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign release_now = own_done || own_drop || at_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    hold_cnt <= hold_cnt + CNT_W'(1);
                    if (release_now) begin
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + IDX_W'(1);
                        // Only a revocation purely by the limit counts as a timeout.
                        timeout   <= at_limit && !own_done && !own_drop;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    dec_2x4_en u_dec (
        .sel (gnt_idx),
        .en  (gnt_valid),
        .y   (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: reset, rotation, hold limit, coincident release, ignored done, async reset.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int vectors = 0;
    int errs    = 0;

    rr_arbiter_4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++)
            if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // Check the full output set against an expected grant vector and timeout.
    task automatic expect_out(input string tag, input logic [3:0] eg, input logic et);
        chk({tag, "_gnt"}, 8'(gnt), 8'(eg));
        chk({tag, "_vld"}, 8'(gnt_valid), 8'(|eg));
        chk({tag, "_to"}, 8'(timeout), 8'(et));
        if (eg != 4'b0000)
            chk({tag, "_idx"}, 8'(gnt_idx), 8'(oh2idx(eg)));
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0100;
        done = 4'b0000;

        // 1: held in reset with a request pending, then a single request
        cyc();
        expect_out("rst_a", 4'b0000, 1'b0);
        chk("rst_idx", 8'(gnt_idx), 8'd0);
        cyc();
        expect_out("rst_b", 4'b0000, 1'b0);
        rst = 1'b0;
        cyc();
        expect_out("single", 4'b0100, 1'b0);
        req = 4'b0000;
        cyc();
        expect_out("drop_gap", 4'b0000, 1'b0);
        cyc();
        expect_out("drop_idle", 4'b0000, 1'b0);

        // 2: done after two cycles, full rotation 0,1,2,3,0
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req = 4'b1111;
        for (int o = 0; o < 5; o++) begin
            cyc();
            expect_out($sformatf("rot%0d_c0", o), 4'b0001 << (o % 4), 1'b0);
            cyc();
            expect_out($sformatf("rot%0d_c1", o), 4'b0001 << (o % 4), 1'b0);
            done = 4'b0001 << (o % 4);
            cyc();
            done = 4'b0000;
            expect_out($sformatf("rot%0d_gap", o), 4'b0000, 1'b0);
            cyc();
            expect_out($sformatf("rot%0d_idle", o), 4'b0000, 1'b0);
        end

        // 3: hold limit with requester 1 waiting
        req = 4'b0011;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            cyc();
            expect_out($sformatf("hold_c%0d", c), 4'b0001, 1'b0);
        end
        cyc();
        expect_out("hold_to", 4'b0000, 1'b1);
        cyc();
        expect_out("hold_idle", 4'b0000, 1'b0);
        cyc();
        expect_out("hold_next", 4'b0010, 1'b0);

        // 4: owner 2 drops req on the limit cycle -> normal release, ptr=3
        req = 4'b0100;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            cyc();
            expect_out($sformatf("coin_c%0d", c), 4'b0100, 1'b0);
        end
        req = 4'b0000;
        cyc();
        expect_out("coin_gap", 4'b0000, 1'b0);
        cyc();
        expect_out("coin_idle", 4'b0000, 1'b0);
        req = 4'b1111;
        cyc();
        expect_out("coin_ptr3", 4'b1000, 1'b0);

        // 5: done of a non-owner is ignored
        req = 4'b0010;
        do_reset();
        cyc();
        expect_out("ign_a", 4'b0010, 1'b0);
        done = 4'b1000;
        cyc();
        done = 4'b0000;
        expect_out("ign_b", 4'b0010, 1'b0);
        cyc();
        expect_out("ign_c", 4'b0010, 1'b0);

        // 6: asynchronous reset while requester 3 owns the grant
        req = 4'b1000;
        do_reset();
        cyc();
        expect_out("async_pre", 4'b1000, 1'b0);
        #2 rst = 1'b1;
        #1;
        expect_out("async_mid", 4'b0000, 1'b0);
        req = 4'b1001;
        cyc();
        rst = 1'b0;
        cyc();
        expect_out("async_post", 4'b0001, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
